// File: rtl/qsort_host_master.sv
// Initiator-side driver for the qsort accelerator: AXI-Lite start, AXI-Stream send,
// ap_done polling and count-based result collection. Optional macro: QSORT_HOST_TIMEOUT_EN.
module qsort_host_master #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pNUM        = 11,
    parameter int pPOLL_GAP   = 4,
    parameter int pTIMEOUT    = 1024
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   src_we,
    input  logic [3:0]             src_idx,
    input  logic [pDATA_WIDTH-1:0] src_wdata,
    input  logic [3:0]             dst_idx,
    output logic [pDATA_WIDTH-1:0] dst_rdata,
    input  logic                   go,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   awvalid,
    output logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   awready,
    output logic                   wvalid,
    output logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   wready,
    output logic                   arvalid,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   arready,
    input  logic                   rvalid,
    input  logic [pDATA_WIDTH-1:0] rdata,
    output logic                   rready,
    output logic                   ss_tvalid,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    input  logic                   ss_tready,
    input  logic                   sm_tvalid,
    input  logic [pDATA_WIDTH-1:0] sm_tdata,
    input  logic                   sm_tlast,
    output logic                   sm_tready
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR_START, S_STREAM, S_POLL_AR, S_POLL_R, S_POLL_GAP, S_COLLECT, S_DONE
    } state_t;

    localparam logic [3:0]    NUM      = 4'(pNUM);
    localparam logic [3:0]    LAST     = 4'(pNUM - 1);
    localparam int            GW       = (pPOLL_GAP > 1) ? $clog2(pPOLL_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(pPOLL_GAP - 1);

    state_t                 state, state_nxt;
    logic [3:0]             cnt, cnt_nxt;
    logic [GW-1:0]          gap, gap_nxt;
    logic                   aw_done, aw_done_nxt, w_done, w_done_nxt;
    logic                   done_q, err_q, timeout;
    logic [pDATA_WIDTH-1:0] src [pNUM];
    logic [pDATA_WIDTH-1:0] dst [pNUM];
    logic                   aw_fire, w_fire, ar_fire, r_fire, ss_fire, sm_fire;

    // Handshake outputs are pure decodes of state so every reset/timeout drops them at once.
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = done_q;
    assign err       = err_q;
    assign awvalid   = (state == S_WR_START) && !aw_done;
    assign wvalid    = (state == S_WR_START) && !w_done;
    assign awaddr    = '0;
    assign araddr    = '0;
    assign wdata     = {{(pDATA_WIDTH-1){1'b0}}, state == S_WR_START};
    assign arvalid   = (state == S_POLL_AR);
    assign rready    = (state == S_POLL_R);
    assign ss_tvalid = (state == S_STREAM);
    assign ss_tdata  = (state == S_STREAM) ? src[cnt] : '0;
    assign ss_tlast  = (state == S_STREAM) && (cnt == LAST);
    assign sm_tready = (state == S_COLLECT);
    assign dst_rdata = (dst_idx < NUM) ? dst[dst_idx] : '0;

    assign aw_fire = awvalid & awready;
    assign w_fire  = wvalid & wready;
    assign ar_fire = arvalid & arready;
    assign r_fire  = rready & rvalid;
    assign ss_fire = ss_tvalid & ss_tready;
    assign sm_fire = sm_tvalid & sm_tready;

    logic unused_sig;
    assign unused_sig = ^{rdata[pDATA_WIDTH-1:2], rdata[0], sm_tlast};

`ifdef QSORT_HOST_TIMEOUT_EN
    logic [31:0] wdog;
    logic        hs;
    assign hs      = aw_fire | w_fire | ar_fire | r_fire | ss_fire | sm_fire;
    assign timeout = busy && (wdog == 32'(pTIMEOUT));

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n)      wdog <= '0;
        else if (!busy || hs) wdog <= '0;
        else                  wdog <= wdog + 32'd1;
    end
`else
    localparam int unused_timeout = pTIMEOUT;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        gap_nxt     = gap;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        case (state)
            S_IDLE:     if (go) state_nxt = S_WR_START;
            S_WR_START: begin
                aw_done_nxt = aw_done | aw_fire;
                w_done_nxt  = w_done | w_fire;
                if (aw_done_nxt && w_done_nxt) begin
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    state_nxt   = S_STREAM;
                end
            end
            S_STREAM: if (ss_fire) begin
                cnt_nxt = (cnt == LAST) ? 4'd0 : cnt + 4'd1;
                if (cnt == LAST) state_nxt = S_POLL_AR;
            end
            S_POLL_AR:  if (ar_fire) state_nxt = S_POLL_R;
            S_POLL_R: if (r_fire) begin
                gap_nxt   = '0;
                state_nxt = rdata[1] ? S_COLLECT : S_POLL_GAP;
            end
            S_POLL_GAP: begin
                gap_nxt = gap + GW'(1);
                if (gap == GAP_LAST) state_nxt = S_POLL_AR;
            end
            S_COLLECT: if (sm_fire) begin
                cnt_nxt = (cnt == LAST) ? 4'd0 : cnt + 4'd1;
                if (cnt == LAST) state_nxt = S_DONE;
            end
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
        if (timeout) begin
            state_nxt   = S_IDLE;
            cnt_nxt     = '0;
            aw_done_nxt = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            gap     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            gap     <= gap_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
            if (state == S_IDLE && go) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                if (state_nxt == S_DONE) done_q <= 1'b1;
                if (timeout)             err_q  <= 1'b1;
            end
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            for (int i = 0; i < pNUM; i++) begin
                src[i] <= '0;
                dst[i] <= '0;
            end
        end else begin
            if (state == S_IDLE && src_we && src_idx < NUM) src[src_idx] <= src_wdata;
            if (sm_fire) dst[cnt] <= sm_tdata;
        end
    end
endmodule

// File: tb/tb_qsort_host_master.sv
// Directed bench for qsort_host_master; the bench itself plays host and accelerator.
module tb_qsort_host_master;
    logic        axis_clk = 1'b0;
    logic        axis_rst_n;
    logic        src_we, go;
    logic [3:0]  src_idx, dst_idx;
    logic [31:0] src_wdata, dst_rdata;
    logic        busy, done, err;
    logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic        ss_tvalid, ss_tlast, ss_tready, sm_tvalid, sm_tlast, sm_tready;
    logic [31:0] ss_tdata, sm_tdata;

    int checks = 0;
    int failures = 0;
    int src_m [11] = '{9, 3, 7, 0, 10, 1, 8, 2, 6, 5, 4};

    always #5 axis_clk = ~axis_clk;

    qsort_host_master dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .src_we(src_we), .src_idx(src_idx), .src_wdata(src_wdata),
        .dst_idx(dst_idx), .dst_rdata(dst_rdata),
        .go(go), .busy(busy), .done(done), .err(err),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wready(wready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rready(rready),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_flags"}, {busy, done, err, awvalid, wvalid, arvalid, rready,
                              ss_tvalid, ss_tlast, sm_tready}, 64'd0);
        chk({tag, "_addr"}, {awaddr, araddr}, 64'd0);
        chk({tag, "_data"}, {wdata, ss_tdata}, 64'd0);
    endtask

    task automatic load_src();
        for (int i = 0; i < 11; i++) begin
            src_we = 1'b1; src_idx = 4'(i); src_wdata = src_m[i];
            @(negedge axis_clk);
        end
        src_we = 1'b0;
    endtask

    task automatic start_job();
        go = 1'b1;
        @(negedge axis_clk);
        go = 1'b0;
        chk("start_busy_done_err", {busy, done, err}, 64'b100);
    endtask

    task automatic do_wr(input int aw_dly, input int w_dly);
        int last = (aw_dly > w_dly) ? aw_dly : w_dly;
        for (int k = 0; k <= last; k++) begin
            chk($sformatf("wr_valids_k%0d", k), {awvalid, wvalid, ss_tvalid},
                {k <= aw_dly, k <= w_dly, 1'b0});
            chk("wr_addr_data", {awaddr, wdata}, {12'h000, 32'h1});
            awready = (k == aw_dly);
            wready  = (k == w_dly);
            @(negedge axis_clk);
        end
        awready = 1'b0; wready = 1'b0;
    endtask

    task automatic do_stream(input logic [3:0] pat, input int nbeats);
        int i = 0;
        int c = 0;
        while (i < nbeats && c < 100) begin
            chk($sformatf("ss_beat%0d", i), {ss_tvalid, ss_tlast, ss_tdata},
                {1'b1, i == 10, 32'(src_m[i])});
            ss_tready = pat[c % 4];
            if (ss_tready) i++;
            c++;
            @(negedge axis_clk);
        end
        ss_tready = 1'b0;
        chk("ss_beats_in_budget", 64'(i), 64'(nbeats));
        if (nbeats == 11) chk("ss_after_last", {ss_tvalid, ss_tlast, arvalid}, 64'b001);
    endtask

    task automatic do_poll(input int n_not_done);
        for (int r = 0; r <= n_not_done; r++) begin
            chk($sformatf("poll_ar%0d", r), {arvalid, rready, 20'(araddr)}, {1'b1, 1'b0, 20'h0});
            arready = 1'b1;
            @(negedge axis_clk);
            arready = 1'b0;
            chk($sformatf("poll_r%0d", r), {arvalid, rready}, 64'b01);
            rvalid = 1'b1;
            rdata  = (r == n_not_done) ? 32'h2 : 32'h1;
            @(negedge axis_clk);
            rvalid = 1'b0; rdata = 32'h0;
            if (r < n_not_done) begin
                for (int g = 0; g < 4; g++) begin
                    chk($sformatf("poll_gap%0d_%0d", r, g), {arvalid, rready, sm_tready}, 64'b000);
                    rvalid = (g == 0);
                    rdata  = (g == 0) ? 32'h2 : 32'h0;
                    @(negedge axis_clk);
                end
                rvalid = 1'b0; rdata = 32'h0;
            end
        end
    endtask

    task automatic do_collect(input int nvalid, input bit go_mid, input logic [31:0] base);
        int ncyc = (nvalid > 13) ? nvalid : 13;
        for (int c = 0; c < ncyc; c++) begin
            chk($sformatf("collect_c%0d", c), {sm_tready, busy, done}, {c < 11, c < 11, c >= 11});
            sm_tvalid = (c < nvalid);
            sm_tdata  = base + 32'(c);
            go        = go_mid && (c == 5);
            src_we    = go_mid && (c == 5);
            src_idx   = 4'd0;
            src_wdata = 32'hDEAD;
            @(negedge axis_clk);
        end
        sm_tvalid = 1'b0; go = 1'b0; src_we = 1'b0;
        chk("job_err_clear", 64'(err), 64'd0);
    endtask

    task automatic check_dst(input logic [31:0] base);
        for (int i = 0; i < 11; i++) begin
            dst_idx = 4'(i);
            #1 chk($sformatf("dst%0d", i), 64'(dst_rdata), 64'(base + 32'(i)));
        end
        dst_idx = 4'd11;
        #1 chk("dst_idx11", 64'(dst_rdata), 64'd0);
        dst_idx = 4'd15;
        #1 chk("dst_idx15", 64'(dst_rdata), 64'd0);
    endtask

    initial begin
        axis_rst_n = 1'b0;
        src_we = 1'b0; src_idx = '0; src_wdata = '0; dst_idx = '0; go = 1'b0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
        ss_tready = 1'b0; sm_tvalid = 1'b0; sm_tdata = '0; sm_tlast = 1'b0;
        repeat (2) @(negedge axis_clk);
        chk_idle_outputs("reset");
        chk("reset_dst", 64'(dst_rdata), 64'd0);
        axis_rst_n = 1'b1;
        @(negedge axis_clk);
        chk_idle_outputs("post_reset");

        // Job 1: all readies high, ap_done on first poll
        load_src();
        start_job();
        do_wr(0, 0);
        do_stream(4'hF, 11);
        do_poll(0);
        do_collect(11, 1'b0, 32'h0);
        check_dst(32'h0);

        // Job 2: delayed AW/W, stalled stream, three not-done polls, surplus beats, host pokes while busy
        start_job();
        do_wr(3, 1);
        do_stream(4'b1001, 11);
        do_poll(3);
        do_collect(20, 1'b1, 32'h50);
        check_dst(32'h50);

        // Job 3: source untouched by the busy write; reset at beat 5
        start_job();
        do_wr(0, 0);
        do_stream(4'hF, 5);
        axis_rst_n = 1'b0;
        #1 chk_idle_outputs("mid_reset");
        dst_idx = 4'd0;
        #1 chk("mid_reset_dst", 64'(dst_rdata), 64'd0);
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        @(negedge axis_clk);

`ifdef QSORT_HOST_TIMEOUT_EN
        begin
            int n = 0;
            load_src();
            start_job();
            do_wr(0, 0);
            while (!err && n < 1200) begin
                @(negedge axis_clk);
                n++;
            end
            chk("timeout_err", 64'(err), 64'd1);
            chk("timeout_cycles", 64'(n >= 1020 && n <= 1030), 64'd1);
            chk("timeout_outputs", {busy, done, ss_tvalid, sm_tready}, 64'b0000);
        end
`else
        chk("no_watchdog_err", 64'(err), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/qsort_host_master.md
Name: qsort_host_master

Overview:
- Initiator-side driver for the qsort accelerator.
- Holds a local source buffer of pNUM words loaded by the host, then:
  - writes ap_start over AXI-Lite,
  - streams the buffer out on AXI-Stream,
  - polls ap_done,
  - collects the sorted words into a local result buffer.
- Sits between the host-side register logic and the accelerator. Its AXI port names mirror the accelerator so they wire 1:1.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite address width.
- pDATA_WIDTH, 32, AXI-Lite and AXI-Stream data width.
- pNUM, 11, words per job (send count and collect count).
- pPOLL_GAP, 4, idle cycles between ap_done status reads.
- pTIMEOUT, 1024, watchdog cycles (used only with the optional feature).

Ports:
- axis_clk  in  1  clock
- axis_rst_n  in  1  asynchronous active-low reset
- src_we  in  1  host write strobe to the source buffer
- src_idx  in  4  source buffer index (0..pNUM-1)
- src_wdata  in  pDATA_WIDTH  source word
- dst_idx  in  4  result buffer read index
- dst_rdata  out  pDATA_WIDTH  result word; combinational read
- go  in  1  single-cycle job start
- busy  out  1  job in progress
- done  out  1  sticky job-complete flag
- err  out  1  sticky timeout flag
- awvalid  out  1  AXI-Lite write address valid
- awaddr  out  pADDR_WIDTH  write address
- awready  in  1  write address ready
- wvalid  out  1  AXI-Lite write data valid
- wdata  out  pDATA_WIDTH  write data
- wready  in  1  write data ready
- arvalid  out  1  AXI-Lite read address valid
- araddr  out  pADDR_WIDTH  read address
- arready  in  1  read address ready
- rvalid  in  1  read data valid
- rdata  in  pDATA_WIDTH  read data
- rready  out  1  read data ready
- ss_tvalid  out  1  stream-out valid
- ss_tdata  out  pDATA_WIDTH  stream-out data
- ss_tlast  out  1  stream-out last
- ss_tready  in  1  stream-out ready
- sm_tvalid  in  1  stream-in valid
- sm_tdata  in  pDATA_WIDTH  stream-in data
- sm_tlast  in  1  stream-in last (ignored; collection is count-based)
- sm_tready  out  1  stream-in ready

Behaviour:
- Reset: FSM=IDLE, all counters 0, buffers 0.
  - Outputs low: busy, done, err, awvalid, wvalid, arvalid, rready, ss_tvalid, ss_tlast, sm_tready.
  - awaddr, araddr, wdata, ss_tdata = 0.
- IDLE:
  - src_we writes the source buffer; writes with src_idx >= pNUM are dropped.
  - go moves to WR_START, sets busy, clears done and err.
- WR_START:
  - awvalid=1, awaddr=0x00; wvalid=1, wdata=0x1.
  - Each valid drops the cycle after its own ready is sampled high. AW and W complete independently, in either order or the same cycle.
  - Go to STREAM once both have completed.
- STREAM:
  - ss_tvalid=1; ss_tdata=src[cnt]; ss_tlast=1 only when cnt==pNUM-1.
  - cnt increments on ss_tvalid&ss_tready. Data and valid are held stable while ss_tready is low.
  - After the last beat: ss_tvalid=0, cnt=0, go to POLL.
- POLL:
  - arvalid=1, araddr=0x00 until arready.
  - Then rready=1 until rvalid.
  - If rdata[1]==1, go to COLLECT. Otherwise wait pPOLL_GAP cycles (gap counter) and re-issue the read.
- COLLECT:
  - sm_tready=1. Each sm_tvalid&sm_tready writes sm_tdata to dst[cnt] and increments cnt.
  - sm_tready drops the cycle after the pNUM-th beat. Surplus valid beats from the accelerator are never accepted.
  - Go to DONE.
- DONE: one cycle; busy=0, done=1 (sticky until the next go); return to IDLE.
- Boundaries:
  - go while busy: ignored.
  - src_we while busy: ignored.
  - dst_rdata is readable in any state; index >= pNUM returns 0.
  - rvalid with no outstanding read: ignored (rready low).
  - Reset mid-job: immediate return to reset values. The buffers clear; the host must reload the source.
- Latency: no extra wait states. With all readies permanently high, WR_START takes 1 cycle and STREAM takes pNUM cycles.

Optional Feature:
- Macro: QSORT_HOST_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs while busy and resets on every completed handshake (AW, W, AR, R, ss beat, sm beat).
  - When it reaches pTIMEOUT: all valids/readies drop, err=1, busy=0, done stays 0, FSM returns to IDLE.
- Undefined: no watchdog logic is built; err is tied 0 and the job waits indefinitely.

Test Plan:
- Load 11 words 9,3,7,0,10,1,8,2,6,5,4 and pulse go; accelerator model with all readies high -> one AXI-Lite write (0x00, 0x1), 11 ss beats with tlast on the 11th, polls until ap_done, dst[0..10]=0..10, done=1, busy=0.
- awready delayed 3 cycles and wready delayed 1 cycle -> wvalid drops after 2 cycles, awvalid after 4; STREAM starts only after both have completed.
- ss_tready toggling 1,0,0,1 -> ss_tdata/ss_tvalid held across stalls; exactly 11 beats accepted in order.
- Model returns ap_done=0 for the first 3 reads -> 4 AR transactions, each pair separated by pPOLL_GAP=4 idle cycles; COLLECT begins only after rdata[1]=1.
- Model keeps sm_tvalid high for 20 beats -> only 11 captured; sm_tready low from the 12th cycle on; go pulsed mid-job is ignored.
- Reset asserted mid-STREAM at beat 5 -> all outputs return to reset values on the same edge. With QSORT_HOST_TIMEOUT_EN and ss_tready stuck low, err=1 after 1024 cycles.
